// File: rtl/sm_norm_round.sv
// fp16 multiplier output stage: normalize the 22-bit significand product, add exponents,
// round to nearest-even and pack binary16. Two registered stages with valid/ready backpressure.
module sm_norm_round #(
  parameter int BIAS = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:0] prod_in,
  input  logic [4:0]  ex_in,
  input  logic [4:0]  ey_in,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result_out,
  output logic        ovf_out,
  output logic        unf_out
);

  typedef struct packed {
    logic signed [6:0] e;
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic              sign;
    logic              zero;
    logic              nz;     // zero-flagged product was nonzero, i.e. a flush
  } s1_t;

  localparam logic signed [6:0] BIAS7 = 7'(BIAS);

  s1_t               s1_d, s1_q;
  logic              s1_valid_q;
  logic              out_valid_q;
  logic [15:0]       res_d, res_q;
  logic              ovf_d, ovf_q, unf_d, unf_q;
  logic              s1_adv, s2_adv;
  logic signed [6:0] e_sum, e_r;
  logic              round_up, carry;
  logic [9:0]        mant_r;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid  = out_valid_q;
  assign result_out = res_q;
  assign ovf_out    = ovf_q;
  assign unf_out    = unf_q;

  // 7-bit signed sum keeps the full range (-15..49) visible to the range checks.
  assign e_sum = $signed({2'b00, ex_in}) + $signed({2'b00, ey_in}) - BIAS7;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign_in;
    if (prod_in[21]) begin
      s1_d.mant   = prod_in[20:11];
      s1_d.guard  = prod_in[10];
      s1_d.sticky = |prod_in[9:0];
      s1_d.e      = e_sum + 7'sd1;
    end else if (prod_in[20]) begin
      s1_d.mant   = prod_in[19:10];
      s1_d.guard  = prod_in[9];
      s1_d.sticky = |prod_in[8:0];
      s1_d.e      = e_sum;
    end else begin
      s1_d.zero = 1'b1;
      s1_d.nz   = |prod_in[19:0];
    end
  end

  always_comb begin
    round_up        = s1_q.guard && (s1_q.sticky || s1_q.mant[0]);
    {carry, mant_r} = {1'b0, s1_q.mant} + {10'd0, round_up};
    e_r             = s1_q.e + $signed({6'd0, carry});
    res_d           = {s1_q.sign, 15'd0};
    ovf_d           = 1'b0;
    unf_d           = 1'b0;
    if (s1_q.zero) begin
      unf_d = s1_q.nz;
    end else if (e_r >= 7'sd31) begin
      res_d = {s1_q.sign, 5'h1F, 10'h000};
      ovf_d = 1'b1;
    end else if (e_r <= 7'sd0) begin
      unf_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, e_r[4:0], mant_r};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_valid_q <= 1'b0;
      res_q       <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

endmodule

// File: tb/tb_sm_norm_round.sv
// Directed-vector bench for sm_norm_round: arithmetic cases, range limits,
// backpressure streaming and asynchronous reset mid-stream.
module tb_sm_norm_round;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] prod_in;
  logic [4:0]  ex_in, ey_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_out;
  logic        ovf_out, unf_out;

  int checks = 0;
  int errors = 0;

  sm_norm_round #(.BIAS(15)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod_in(prod_in), .ex_in(ex_in), .ey_in(ey_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .ovf_out(ovf_out), .unf_out(unf_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [21:0] p, input logic [4:0] ex,
                       input logic [4:0] ey, input logic s);
    in_valid = v; prod_in = p; ex_in = ex; ey_in = ey; sign_in = s;
  endtask

  // One isolated transaction: accepted at the next posedge, result two edges later.
  task automatic run_one(input string tag, input logic [21:0] p, input logic [4:0] ex,
                         input logic [4:0] ey, input logic s, input logic [15:0] er,
                         input logic eo, input logic eu);
    @(negedge clk_in);
    out_ready = 1'b1;
    drive(1'b1, p, ex, ey, s);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    @(negedge clk_in);
    drive(1'b0, 22'd0, 5'd0, 5'd0, 1'b0);
    chk({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk_in);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, result_out, er);
    chk({tag, "_ovf"}, ovf_out, eo);
    chk({tag, "_unf"}, unf_out, eu);
  endtask

  logic [4:0]  s_ey   [8] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
  logic [15:0] s_exp  [8] = '{16'h2C00, 16'h3000, 16'h3400, 16'h3800,
                              16'h3C00, 16'h4000, 16'h4400, 16'h4800};
  logic        or_tab [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        ir_tab [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int idx, ocnt;
    rst_in = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 22'd0, 5'd0, 5'd0, 1'b0);
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result_out, 16'h0000);
    chk("rst_flags", {ovf_out, unf_out}, 2'b00);
    @(negedge clk_in);
    rst_in = 1'b1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    run_one("unit",      22'h100000, 5'd15, 5'd15, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_one("norm",      22'h240000, 5'd15, 5'd15, 1'b0, 16'h4080, 1'b0, 1'b0);
    run_one("norm_neg",  22'h240000, 5'd15, 5'd15, 1'b1, 16'hC080, 1'b0, 1'b0);
    run_one("tie_even",  22'h181200, 5'd15, 5'd15, 1'b0, 16'h3E04, 1'b0, 1'b0);
    run_one("tie_odd",   22'h181E00, 5'd15, 5'd15, 1'b0, 16'h3E08, 1'b0, 1'b0);
    run_one("sticky",    22'h100801, 5'd15, 5'd15, 1'b0, 16'h3C02, 1'b0, 1'b0);
    run_one("rnd_carry", 22'h1FFE00, 5'd15, 5'd15, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_one("ovf",       22'h100000, 5'd30, 5'd30, 1'b0, 16'h7C00, 1'b1, 1'b0);
    run_one("ovf_rnd",   22'h1FFE00, 5'd30, 5'd15, 1'b1, 16'hFC00, 1'b1, 1'b0);
    run_one("max_e30",   22'h100000, 5'd30, 5'd15, 1'b0, 16'h7800, 1'b0, 1'b0);
    run_one("unf",       22'h100000, 5'd1,  5'd1,  1'b0, 16'h0000, 1'b0, 1'b1);
    run_one("min_e1",    22'h100000, 5'd1,  5'd15, 1'b0, 16'h0400, 1'b0, 1'b0);
    run_one("unf_e0",    22'h100000, 5'd0,  5'd15, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_one("zero",      22'h000000, 5'd15, 5'd15, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_one("sub_flush", 22'h0C0000, 5'd15, 5'd15, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Backpressure stream: inputs always offered, out_ready from a per-cycle table.
    idx = 0; ocnt = 0;
    for (int cyc = 0; cyc < 40 && ocnt < 8; cyc++) begin
      @(negedge clk_in);
      out_ready = (cyc < 13) ? or_tab[cyc] : 1'b1;
      if (idx < 8) drive(1'b1, 22'h100000, 5'd15, s_ey[idx], 1'b0);
      else         drive(1'b0, 22'd0, 5'd0, 5'd0, 1'b0);
      #1;
      if (cyc < 11) chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, ir_tab[cyc]);
      if (out_valid) begin
        chk($sformatf("bp_res_c%0d", cyc), result_out, s_exp[ocnt]);
        if (out_ready) ocnt++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("bp_count", ocnt, 8);
    @(negedge clk_in);
    drive(1'b0, 22'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("bp_no_dup", out_valid, 1'b0);

    // Fill both stages under stall, then reset asynchronously.
    @(negedge clk_in);
    out_ready = 1'b0;
    drive(1'b1, 22'h100000, 5'd15, 5'd15, 1'b0);
    @(negedge clk_in);
    drive(1'b1, 22'h240000, 5'd15, 5'd15, 1'b0);
    @(negedge clk_in);
    drive(1'b0, 22'd0, 5'd0, 5'd0, 1'b0);
    chk("mid_full_vld", out_valid, 1'b1);
    chk("mid_full_rdy", in_ready, 1'b0);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_res", result_out, 16'h0000);
    chk("mid_rst_rdy", in_ready, 1'b1);
    @(negedge clk_in);
    rst_in = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_stale", out_valid, 1'b0);
    run_one("post_rst", 22'h181E00, 5'd15, 5'd15, 1'b1, 16'hBE08, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
